filter_scan_controller: RTL
===========================

FILTER_SCAN_CONTROLLER -- requirements
Module: filter_scan_controller

Interface
REQ-001 Parameters SHALL be, one per line:
- IMG_W, 640, image width in pixels.
- IMG_H, 480, image height in pixels.
- WIN, 3, square window edge; odd, 1 <= WIN <= min(IMG_W, IMG_H).
- PIPE_LAT, 2, filter datapath latency in cycles, >= 1.
- COORD_W, 32, coordinate width.
REQ-002 Ports SHALL be, one per line:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- en_filter  in  1  start request, sampled in IDLE and DONE.
- abort  in  1  cancel the scan in progress.
- mem_ready  in  1  memory accepts the current read or write this cycle.
- read_enable  out  1  read request.
- read_x, read_y  out  COORD_W  pixel coordinates of the current read.
- write_enable  out  1  result write request at (anchor_x, anchor_y).
- anchor_moving  out  1  anchor advances at the end of this cycle.
- anchor_x, anchor_y  out  COORD_W  current window centre.
- busy  out  1  high in every state except IDLE and DONE.
- process_done  out  1  all anchors processed.
REQ-003 Reset SHALL be synchronous and active-high on rst, with clock clk; this is a single-clock design.

Function
REQ-004 Define R = (WIN-1)/2. Anchors SHALL run in raster order: x from R to IMG_W-1-R inner, y from R to IMG_H-1-R outer.
REQ-005 The FSM SHALL have states IDLE, FILL, COL, DRAIN, WRITE, MOVE and DONE, with Moore, registered outputs.
REQ-006 In IDLE or DONE, en_filter=1 SHALL move the FSM to FILL on the next cycle, with the anchor set to (R,R); process_done SHALL clear on leaving DONE.
REQ-007 FILL SHALL issue WIN*WIN reads in column-major order: x from anchor_x-R to anchor_x+R outer, y from anchor_y-R to anchor_y+R inner.
REQ-008 COL (sliding reuse) SHALL issue WIN reads at x = anchor_x+R, with y from anchor_y-R to anchor_y+R.
REQ-009 read_enable SHALL be 1 throughout FILL and COL.
- A read completes in a cycle with read_enable=1 and mem_ready=1.
- read_x and read_y SHALL hold until that read completes, then advance.
REQ-010 After the last read completes, the FSM SHALL enter DRAIN for exactly PIPE_LAT cycles, independent of mem_ready, then enter WRITE.
REQ-011 In WRITE, write_enable SHALL be held at 1 until a cycle with mem_ready=1, which completes the write.
REQ-012 After the write completes:
- If the anchor is the last one, the FSM SHALL go to DONE.
- Otherwise it SHALL go to MOVE for one cycle with anchor_moving=1.
REQ-013 At the end of MOVE, the anchor SHALL update as follows:
- If anchor_x < IMG_W-1-R: anchor_x+1, next state COL.
- Else: anchor_x=R, anchor_y+1, next state FILL.
REQ-014 DONE SHALL hold process_done=1 until en_filter=1 (restart per REQ-006) or rst.
REQ-015 en_filter SHALL be ignored while busy=1.
REQ-016 abort=1 in any busy state SHALL cause the following on the next cycle:
- IDLE, with all outputs at their reset values.
- No write_enable pulse and no process_done.
- abort takes priority over all transitions except rst.
REQ-017 abort in IDLE or DONE SHALL have no effect.
REQ-018 With WIN=1, FILL and COL SHALL each be exactly one read.
REQ-019 With IMG_W = WIN, every row SHALL use FILL only, with no COL.
REQ-020 Coordinate counters SHALL be COORD_W wide and never wrap; the read coordinate range SHALL be within 0..IMG_W-1 and 0..IMG_H-1.

Reset
REQ-021 While rst=1 at a rising edge, the block SHALL go to IDLE with the following outputs:
- read_enable=0, write_enable=0, anchor_moving=0, busy=0, process_done=0.
- read_x=0, read_y=0.
- anchor_x=R, anchor_y=R.
REQ-022 rst SHALL override abort, en_filter and mem_ready.
REQ-023 A scan in progress when rst is asserted SHALL be discarded, with no residual write.

Verification
REQ-024 The bench SHALL cover these scenarios (WIN=3, PIPE_LAT=2 unless stated):
- IMG 5x4, mem_ready=1, en_filter pulse:
  - process_done rises 53 cycles after the first FILL cycle.
  - Exactly 6 write_enable pulses, at anchors (1,1)..(3,1) then (1,2)..(3,2).
  - 5 anchor_moving pulses.
- First anchor read order, with a mem_ready=0 stall on read 4:
  - Reads (0,0),(0,1),(0,2),(1,0),(1,0 held),(1,1)...(2,2).
  - 10 read_enable cycles in total.
- COL after MOVE to (2,1): reads only (3,0),(3,1),(3,2).
- mem_ready=0 for 4 cycles in WRITE: write_enable held 5 cycles; exactly one write counted.
- abort during DRAIN of anchor (2,2): next cycle IDLE, anchor (1,1), busy=0, process_done=0, no write.
- rst mid-FILL, then a new en_filter: the full scan restarts from (0,0) and matches the first scenario.
- WIN=1, IMG 2x2: 4 anchors, each with 1 read, and 4 writes.

Source files
------------

// File: rtl/filter_scan_controller.sv
// Sliding-window scan controller: walks filter anchors in raster order, issuing
// window reads (full fill at row start, one new column otherwise) and one result write per anchor.
module filter_scan_controller #(
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int WIN      = 3,
  parameter int PIPE_LAT = 2,
  parameter int COORD_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_filter,
  input  logic               abort,
  input  logic               mem_ready,
  output logic               read_enable,
  output logic [COORD_W-1:0] read_x,
  output logic [COORD_W-1:0] read_y,
  output logic               write_enable,
  output logic               anchor_moving,
  output logic [COORD_W-1:0] anchor_x,
  output logic [COORD_W-1:0] anchor_y,
  output logic               busy,
  output logic               process_done
);

  localparam int R = (WIN - 1) / 2;
  localparam logic [COORD_W-1:0] RV     = COORD_W'(R);
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IMG_W - 1 - R);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(IMG_H - 1 - R);
  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [DW-1:0] D_LAST = DW'(PIPE_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_COL, S_DRAIN, S_WRITE, S_MOVE, S_DONE
  } state_t;

  state_t state, state_nxt;
  logic [DW-1:0] drain_cnt;
  logic rd_fire, rd_last, anchor_last, row_end, kill;

  assign rd_fire     = read_enable && mem_ready;
  // FILL ends on the bottom of the rightmost column; COL only ever reads that column
  assign rd_last     = (read_y == anchor_y + RV) &&
                       (state == S_COL || read_x == anchor_x + RV);
  assign row_end     = (anchor_x == X_LAST);
  assign anchor_last = row_end && (anchor_y == Y_LAST);
  assign kill        = abort && busy;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    read_enable   = 1'b0;
    write_enable  = 1'b0;
    anchor_moving = 1'b0;
    busy          = 1'b1;
    process_done  = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (en_filter) state_nxt = S_FILL;
      end
      S_DONE: begin
        busy         = 1'b0;
        process_done = 1'b1;
        if (en_filter) state_nxt = S_FILL;
      end
      S_FILL, S_COL: begin
        read_enable = 1'b1;
        if (mem_ready && rd_last) state_nxt = S_DRAIN;
      end
      S_DRAIN: if (drain_cnt == D_LAST) state_nxt = S_WRITE;
      S_WRITE: begin
        write_enable = 1'b1;
        if (mem_ready) state_nxt = anchor_last ? S_DONE : S_MOVE;
      end
      S_MOVE: begin
        anchor_moving = 1'b1;
        state_nxt     = row_end ? S_FILL : S_COL;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (abort && state != S_IDLE && state != S_DONE) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst || kill) begin
      anchor_x  <= RV;
      anchor_y  <= RV;
      read_x    <= '0;
      read_y    <= '0;
      drain_cnt <= '0;
    end else begin
      drain_cnt <= (state == S_DRAIN) ? drain_cnt + 1'b1 : '0;
      case (state)
        S_IDLE, S_DONE: if (en_filter) begin
          anchor_x <= RV;
          anchor_y <= RV;
          read_x   <= '0;
          read_y   <= '0;
        end
        S_FILL: if (rd_fire && !rd_last) begin
          if (read_y == anchor_y + RV) begin
            read_x <= read_x + 1'b1;
            read_y <= anchor_y - RV;
          end else begin
            read_y <= read_y + 1'b1;
          end
        end
        S_COL: if (rd_fire && !rd_last) read_y <= read_y + 1'b1;
        // read pointer is preloaded here so FILL/COL start on their first read
        S_MOVE: begin
          if (row_end) begin
            anchor_x <= RV;
            anchor_y <= anchor_y + 1'b1;
            read_x   <= '0;
            read_y   <= anchor_y + 1'b1 - RV;
          end else begin
            anchor_x <= anchor_x + 1'b1;
            read_x   <= anchor_x + 1'b1 + RV;
            read_y   <= anchor_y - RV;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
